// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory access arbiter.
// Port 0 is instruction fetch, port 1 is data load/store.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } arb_port_t;

    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } mem_req_t;

    // One-hot per-port strobe for a port id
    function automatic logic [1:0] port_onehot(input arb_port_t p);
        logic [1:0] oh;
        if (p == PORT_DATA) begin
            oh = 2'b10;
        end else begin
            oh = 2'b01;
        end
        return oh;
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant for the memory arbiter.
// Build option MEM_ARB_RR_EN: when defined, ties go to the port that did
// not win last time (round-robin); otherwise the data port wins ties.
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_valid,
`ifdef MEM_ARB_RR_EN
    input  arb_port_t  last_grant,
`endif
    output logic       grant_valid,
    output arb_port_t  grant_port
);

    // Choose a single winner among the currently valid ports
    always_comb begin
        grant_valid = |req_valid;
        grant_port  = PORT_FETCH;
        case (req_valid)
            2'b01: grant_port = PORT_FETCH;
            2'b10: grant_port = PORT_DATA;
            2'b11: begin
`ifdef MEM_ARB_RR_EN
                if (last_grant == PORT_DATA) begin
                    grant_port = PORT_FETCH;
                end else begin
                    grant_port = PORT_DATA;
                end
`else
                grant_port = PORT_DATA;
`endif
            end
            default: grant_port = PORT_FETCH;
        endcase
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one single-port memory between the fetch port (0) and the data
// port (1). Non-pipelined: accept (IDLE) -> strobe (ISSUE) -> respond (RESP).
// Build option MEM_ARB_RR_EN selects round-robin tie breaking; without it
// the data port has fixed priority and no last-grant state is kept.
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    input  logic [1:0]             req_we,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][DATA_W-1:0] req_wdata,
    output logic [1:0]             req_ready,
    output logic [1:0]             resp_valid,
    output logic [DATA_W-1:0]      resp_rdata,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_data_in,
    input  logic [DATA_W-1:0]      mem_data_out
);

    arb_state_t        state_q, state_d;
    arb_port_t         port_q, port_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;

    logic              grant_valid_s;
    arb_port_t         grant_port_s;
    logic              handshake_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

`ifdef MEM_ARB_RR_EN
    arb_port_t         last_grant_q, last_grant_d;
`endif

    mem_arb_grant u_grant (
        .req_valid   (req_valid),
`ifdef MEM_ARB_RR_EN
        .last_grant  (last_grant_q),
`endif
        .grant_valid (grant_valid_s),
        .grant_port  (grant_port_s)
    );

    // Offer ready only to the winner, only while idle and out of reset
    always_comb begin
        req_ready = 2'b00;
        if ((state_q == IDLE) && !rst && grant_valid_s) begin
            req_ready = port_onehot(grant_port_s);
        end else begin
            req_ready = 2'b00;
        end
    end

    assign handshake_s = |(req_valid & req_ready);

    // Route the winning port's request fields toward the latches
    always_comb begin
        sel_we_s    = req_we[0];
        sel_addr_s  = req_addr[0];
        sel_wdata_s = req_wdata[0];
        if (grant_port_s == PORT_DATA) begin
            sel_we_s    = req_we[1];
            sel_addr_s  = req_addr[1];
            sel_wdata_s = req_wdata[1];
        end else begin
            sel_we_s    = req_we[0];
            sel_addr_s  = req_addr[0];
            sel_wdata_s = req_wdata[0];
        end
    end

    // Sequencer: latch on handshake, strobe for one cycle, then respond
    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (handshake_s) begin
                    state_d     = ISSUE;
                    port_d      = grant_port_s;
                    we_d        = sel_we_s;
                    addr_d      = sel_addr_s;
                    wdata_d     = sel_wdata_s;
                    mem_read_d  = !sel_we_s;
                    mem_write_d = sel_we_s;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, request latches and memory strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            port_q      <= PORT_FETCH;
            we_q        <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Remember who won the most recent handshake for tie breaking
    always_comb begin
        if (handshake_s) begin
            last_grant_d = grant_port_s;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Last-grant register; starts at the data port so fetch wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= PORT_DATA;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // Response pulse; read data comes straight from the memory's output
    // register, which is only valid in the RESP cycle
    always_comb begin
        resp_valid = 2'b00;
        resp_rdata = {DATA_W{1'b0}};
        if ((state_q == RESP) && !rst) begin
            resp_valid = port_onehot(port_q);
            if (we_q) begin
                resp_rdata = {DATA_W{1'b0}};
            end else begin
                resp_rdata = mem_data_out;
            end
        end else begin
            resp_valid = 2'b00;
            resp_rdata = {DATA_W{1'b0}};
        end
    end

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_addr    = addr_q;
    assign mem_data_in = wdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: 32x8 memory behind the arbiter, a reference
// memory image and a response scoreboard. Honours MEM_ARB_RR_EN.
module tb_mem_access_arbiter;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      req_valid = 2'b00;
    logic [1:0]      req_we = 2'b00;
    logic [1:0][4:0] req_addr = '0;
    logic [1:0][7:0] req_wdata = '0;
    logic [1:0]      req_ready;
    logic [1:0]      resp_valid;
    logic [7:0]      resp_rdata;
    logic            mem_read;
    logic            mem_write;
    logic [4:0]      mem_addr;
    logic [7:0]      mem_data_in;
    logic [7:0]      mem_data_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] mem [32];
    logic [7:0] ref_mem [32];

    typedef struct {
        int         port;
        logic [7:0] rdata;
        int         due;
    } exp_t;
    exp_t sb_q[$];

    logic       hs_prev = 1'b0;
    logic       hs_we_prev = 1'b0;
    logic [4:0] hs_addr_prev = 5'd0;
    logic [7:0] hs_wdata_prev = 8'd0;

`ifdef MEM_ARB_RR_EN
    localparam logic [1:0] TIE_FIRST = 2'b01;
`else
    localparam logic [1:0] TIE_FIRST = 2'b10;
`endif

    mem_access_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    // cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // 32x8 memory with registered read data
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'(i * 7 + 3);
        mem_data_out = 8'h00;
        forever begin
            @(posedge clk);
            if (mem_write) mem[mem_addr] <= mem_data_in;
            if (mem_read) mem_data_out <= mem[mem_addr];
        end
    end

    // monitor: reference memory, scoreboard, strobe and ready rules
    initial begin
        exp_t e;
        logic [1:0] exp_rv;
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'(i * 7 + 3);
        forever begin
            @(negedge clk);
            checks++;
            if (mem_read !== (hs_prev & ~hs_we_prev) || mem_write !== (hs_prev & hs_we_prev)) begin
                failures++;
                $display("FAIL strobe cyc=%0d got rd=%b wr=%b expected rd=%b wr=%b", cyc, mem_read, mem_write,
                         hs_prev & ~hs_we_prev, hs_prev & hs_we_prev);
            end
            if (hs_prev) begin
                checks++;
                if (mem_addr !== hs_addr_prev || (hs_we_prev && mem_data_in !== hs_wdata_prev)) begin
                    failures++;
                    $display("FAIL mem_bus cyc=%0d got addr=%0d din=%h expected addr=%0d din=%h", cyc, mem_addr,
                             mem_data_in, hs_addr_prev, hs_wdata_prev);
                end
            end
            checks++;
            if ($countones(req_ready) > 1) begin
                failures++;
                $display("FAIL ready_onehot cyc=%0d got %b expected at most one bit", cyc, req_ready);
            end
            if (rst) begin
                checks++;
                if (resp_valid !== 2'b00 || req_ready !== 2'b00) begin
                    failures++;
                    $display("FAIL rst_quiet cyc=%0d got resp_valid=%b ready=%b expected 00/00", cyc, resp_valid, req_ready);
                end
                sb_q.delete();
                hs_prev = 1'b0;
            end else begin
                if (resp_valid !== 2'b00) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        failures++;
                        $display("FAIL resp_dup cyc=%0d got resp_valid=%b expected none", cyc, resp_valid);
                    end else begin
                        e = sb_q.pop_front();
                        exp_rv = (e.port == 1) ? 2'b10 : 2'b01;
                        if (resp_valid !== exp_rv || resp_rdata !== e.rdata || cyc != e.due) begin
                            failures++;
                            $display("FAIL resp_sb cyc=%0d got rv=%b data=%h expected rv=%b data=%h at cyc=%0d", cyc,
                                     resp_valid, resp_rdata, exp_rv, e.rdata, e.due);
                        end
                    end
                end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL resp_lost cyc=%0d got no resp expected port=%0d data=%h", cyc, sb_q[0].port, sb_q[0].rdata);
                    void'(sb_q.pop_front());
                end
                hs_prev = 1'b0;
                for (int p = 0; p < 2; p++) begin
                    if (req_valid[p] && req_ready[p]) begin
                        hs_prev       = 1'b1;
                        hs_we_prev    = req_we[p];
                        hs_addr_prev  = req_addr[p];
                        hs_wdata_prev = req_wdata[p];
                        e.port  = p;
                        e.due   = cyc + 2;
                        e.rdata = req_we[p] ? 8'h00 : ref_mem[req_addr[p]];
                        sb_q.push_back(e);
                        if (req_we[p]) ref_mem[req_addr[p]] = req_wdata[p];
                    end
                end
            end
        end
    end

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic drive(input int p, input logic we, input logic [4:0] addr, input logic [7:0] wdata);
        req_we[p]    = we;
        req_addr[p]  = addr;
        req_wdata[p] = wdata;
        req_valid[p] = 1'b1;
    endtask

    task automatic wait_accept(input int p, output int t);
        bit got = 1'b0;
        t = -1;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (req_valid[p] && req_ready[p]) begin
                got = 1'b1;
                t = cyc;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL accept_timeout port=%0d got no ready expected ready within 40 cycles", p);
        end
    endtask

    task automatic wait_any(output int p, output int t);
        bit got = 1'b0;
        p = -1;
        t = -1;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != 2'b00) begin
                got = 1'b1;
                t = cyc;
                p = req_ready[1] ? 1 : 0;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL any_timeout got no ready expected ready within 40 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_we = 2'b00;
        req_addr[0] = 5'd1;
        req_addr[1] = 5'd2;
        req_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({req_ready, resp_valid, resp_rdata, mem_read, mem_write, mem_addr, mem_data_in} !== 27'd0) begin
                failures++;
                $display("FAIL reset_outputs got ready=%b rv=%b rd=%h r=%b w=%b a=%0d d=%h expected all 0",
                         req_ready, resp_valid, resp_rdata, mem_read, mem_write, mem_addr, mem_data_in);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== TIE_FIRST) begin
            failures++;
            $display("FAIL reset_first_ready got %b expected %b", req_ready, TIE_FIRST);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int t;
        drive(1, 1'b1, 5'd5, 8'hA5);
        wait_accept(1, t);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 5'd5 || mem_data_in !== 8'hA5) begin
            failures++;
            $display("FAIL store_strobe got w=%b r=%b a=%0d d=%h expected 1 0 5 a5", mem_write, mem_read, mem_addr, mem_data_in);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b10 || resp_rdata !== 8'h00 || cyc != t + 2) begin
            failures++;
            $display("FAIL store_resp got rv=%b d=%h cyc=%0d expected 10 00 cyc=%0d", resp_valid, resp_rdata, cyc, t + 2);
        end
        @(posedge clk); #1;
        drive(1, 1'b0, 5'd5, 8'h00);
        wait_accept(1, t);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 5'd5) begin
            failures++;
            $display("FAIL load_strobe got r=%b w=%b a=%0d expected 1 0 5", mem_read, mem_write, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 2'b10 || resp_rdata !== 8'hA5 || cyc != t + 2) begin
            failures++;
            $display("FAIL load_resp got rv=%b d=%h cyc=%0d expected 10 a5 cyc=%0d", resp_valid, resp_rdata, cyc, t + 2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_tie();
        int fp;
        int pa, ta, pb, tb, p, t, prev, exp_p;
        fp = TIE_FIRST[1] ? 1 : 0;
        req_we = 2'b00;
        req_addr[0] = 5'd0;
        req_addr[1] = 5'd31;
        req_valid = 2'b11;
        wait_any(pa, ta);
        checks++;
        if (pa != fp) begin
            failures++;
            $display("FAIL tie_first got port=%0d expected port=%0d", pa, fp);
        end
        @(posedge clk); #1;
        if (pa >= 0) req_valid[pa] = 1'b0;
        wait_any(pb, tb);
        checks++;
        if (pb != 1 - fp || tb - ta != 3) begin
            failures++;
            $display("FAIL tie_second got port=%0d gap=%0d expected port=%0d gap=3", pb, tb - ta, 1 - fp);
        end
        @(posedge clk); #1;
        req_valid = 2'b11;
        prev = tb;
        for (int k = 0; k < 10; k++) begin
            wait_any(p, t);
`ifdef MEM_ARB_RR_EN
            exp_p = k % 2;
`else
            exp_p = 1;
`endif
            checks++;
            if (p != exp_p || t - prev != 3) begin
                failures++;
                $display("FAIL tie_b2b k=%0d got port=%0d gap=%0d expected port=%0d gap=3", k, p, t - prev, exp_p);
            end
            prev = t;
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_boundary();
        logic       we_a [4];
        logic [4:0] ad_a [4];
        logic [7:0] wd_a [4];
        logic [7:0] ex_a [4];
        int t, prev;
        we_a[0] = 1'b1; ad_a[0] = 5'd31; wd_a[0] = 8'hFF; ex_a[0] = 8'h00;
        we_a[1] = 1'b1; ad_a[1] = 5'd0;  wd_a[1] = 8'h00; ex_a[1] = 8'h00;
        we_a[2] = 1'b0; ad_a[2] = 5'd31; wd_a[2] = 8'h00; ex_a[2] = 8'hFF;
        we_a[3] = 1'b0; ad_a[3] = 5'd0;  wd_a[3] = 8'h00; ex_a[3] = 8'h00;
        prev = 0;
        drive(0, we_a[0], ad_a[0], wd_a[0]);
        for (int i = 0; i < 4; i++) begin
            wait_accept(0, t);
            if (i > 0) begin
                checks++;
                if (t - prev != 3) begin
                    failures++;
                    $display("FAIL bound_gap i=%0d got %0d expected 3", i, t - prev);
                end
            end
            prev = t;
            @(posedge clk); #1;
            if (i == 3) req_valid[0] = 1'b0;
            else drive(0, we_a[i+1], ad_a[i+1], wd_a[i+1]);
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (resp_valid !== 2'b01 || resp_rdata !== ex_a[i]) begin
                failures++;
                $display("FAIL bound_resp i=%0d got rv=%b d=%h expected 01 %h", i, resp_valid, resp_rdata, ex_a[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_issue();
        int t;
        drive(1, 1'b1, 5'd7, 8'h3C);
        wait_accept(1, t);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        drive(0, 1'b0, 5'd7, 8'h00);
        wait_accept(0, t);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 2'b00) begin
                failures++;
                $display("FAIL rst_issue_noresp i=%0d got %b expected 00", i, resp_valid);
            end
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 5'd7, 8'h00);
        wait_accept(0, t);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (resp_valid !== 2'b01 || resp_rdata !== 8'h3C) begin
            failures++;
            $display("FAIL rst_issue_next got rv=%b d=%h expected 01 3c", resp_valid, resp_rdata);
        end
        @(posedge clk); #1;
        drive(1, 1'b1, 5'd9, 8'h5A);
        wait_accept(1, t);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (mem[9] !== 8'h5A || resp_valid !== 2'b00) begin
            failures++;
            $display("FAIL rst_issue_store got mem=%h rv=%b expected 5a 00", mem[9], resp_valid);
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 5'd9, 8'h00);
        wait_accept(0, t);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (resp_valid !== 2'b01 || resp_rdata !== 8'h5A) begin
            failures++;
            $display("FAIL rst_issue_reload got rv=%b d=%h expected 01 5a", resp_valid, resp_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int accepted = 0;
        int n = 0;
        logic [1:0] acc;
        req_valid = 2'b00;
        while (accepted < 2000 && n < 30000) begin
            for (int p = 0; p < 2; p++) begin
                if (!req_valid[p] && $urandom_range(0, 9) < 6) begin
                    drive(p, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
                end
            end
            @(negedge clk);
            n++;
            acc = req_valid & req_ready;
            accepted += $countones(acc);
            @(posedge clk); #1;
            req_valid = req_valid & ~acc;
        end
        checks++;
        if (accepted < 2000) begin
            failures++;
            $display("FAIL random_progress got %0d accepts expected 2000", accepted);
        end
        req_valid = 2'b00;
        repeat (4) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL random_drain got %0d pending expected 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_boundary();
        test_reset_issue();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
